tcdm_bank_resp: RTL



---
 rtl/tcdm_bank_resp.sv | 118 +++++++++++
 1 files changed

// File: rtl/tcdm_bank_resp.sv
// rtl/tcdm_bank_resp.sv - single-bank TCDM responder, four ports arbitrated round-robin onto one SRAM word bank
// Optional grant-stall LFSR is built when TCDM_BANK_RESP_STALL_EN is defined.
module tcdm_bank_resp #(
  parameter int TRANS_SID_WIDTH = 1,
  parameter int MEM_ADD_WIDTH   = 10
) (
  input  logic                            clk_i,
  input  logic                            rst_i,
  input  logic [3:0]                      tcdm_req_i,
  input  logic [3:0][31:0]                tcdm_add_i,
  input  logic [3:0]                      tcdm_we_i,
  input  logic [3:0][31:0]                tcdm_wdata_i,
  input  logic [3:0][3:0]                 tcdm_be_i,
  input  logic [3:0][TRANS_SID_WIDTH-1:0] tcdm_sid_i,
  output logic [3:0]                      tcdm_gnt_o,
  output logic [3:0][31:0]                tcdm_r_rdata_o,
  output logic [3:0]                      tcdm_r_valid_o,
  output logic [3:0][TRANS_SID_WIDTH-1:0] tcdm_r_sid_o
);

  localparam int DEPTH = 1 << MEM_ADD_WIDTH;

  logic [1:0]                      rr_q, rr_d;
  logic [1:0]                      cand;
  logic [1:0]                      gnt_idx;
  logic                            gnt_any;
  logic [3:0]                      gnt;
  logic                            stall;
  logic [MEM_ADD_WIDTH-1:0]        word_idx;
  logic [31:0]                     mem_q [DEPTH];
  logic [3:0]                      r_valid_q, r_valid_d;
  logic [3:0][31:0]                r_rdata_q, r_rdata_d;
  logic [3:0][TRANS_SID_WIDTH-1:0] r_sid_q, r_sid_d;
  logic                            add_unused;

  // Only the word-index slice of each address is decoded.
  assign add_unused = ^tcdm_add_i;

`ifdef TCDM_BANK_RESP_STALL_EN
  logic [7:0] lfsr_q, lfsr_d;

  always_comb begin
    lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) lfsr_q <= 8'hA5;
    else       lfsr_q <= lfsr_d;
  end

  assign stall = lfsr_q[0];
`else
  assign stall = 1'b0;
`endif

  always_comb begin
    cand    = rr_q;
    gnt_idx = rr_q;
    gnt_any = 1'b0;
    gnt     = '0;
    for (int i = 0; i < 4; i++) begin
      cand = rr_q + 2'(i);
      if (!gnt_any && tcdm_req_i[cand]) begin
        gnt_any = 1'b1;
        gnt_idx = cand;
      end
    end
    if (rst_i || stall) gnt_any = 1'b0;
    if (gnt_any) gnt[gnt_idx] = 1'b1;
  end

  assign tcdm_gnt_o = gnt;
  assign word_idx   = tcdm_add_i[gnt_idx][MEM_ADD_WIDTH+1:2];

  always_comb begin
    rr_d = gnt_any ? gnt_idx + 2'd1 : rr_q;
  end

  // Non-granted ports keep their last response data.
  always_comb begin
    r_valid_d = '0;
    r_rdata_d = r_rdata_q;
    r_sid_d   = r_sid_q;
    if (gnt_any && !tcdm_we_i[gnt_idx]) begin
      r_valid_d[gnt_idx] = 1'b1;
      r_rdata_d[gnt_idx] = mem_q[word_idx];
      r_sid_d[gnt_idx]   = tcdm_sid_i[gnt_idx];
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rr_q      <= 2'd0;
      r_valid_q <= '0;
      r_rdata_q <= '0;
      r_sid_q   <= '0;
    end else begin
      rr_q      <= rr_d;
      r_valid_q <= r_valid_d;
      r_rdata_q <= r_rdata_d;
      r_sid_q   <= r_sid_d;
    end
  end

  // Bank contents are deliberately not reset.
  always_ff @(posedge clk_i) begin
    if (gnt_any && tcdm_we_i[gnt_idx]) begin
      for (int b = 0; b < 4; b++) begin
        if (tcdm_be_i[gnt_idx][b]) mem_q[word_idx][8*b +: 8] <= tcdm_wdata_i[gnt_idx][8*b +: 8];
      end
    end
  end

  assign tcdm_r_valid_o = r_valid_q;
  assign tcdm_r_rdata_o = r_rdata_q;
  assign tcdm_r_sid_o   = r_sid_q;

endmodule
